// File: rtl/axis_pkt_pkg.sv
// Shared types and defaults for the AXIS store-and-forward packet FIFO.
//   DEPTH_DEFAULT      default number of beat entries
//   PTR_WIDTH          pointer width for the default depth (address + wrap bit)
//   *_WIDTH_DEFAULT    default AXIS field widths
//   ptr_t              pointer type for the default depth
//   beat_t             one stored beat {last, user, id, dest, data}
package axis_pkt_pkg;

    localparam int unsigned DEPTH_DEFAULT      = 16;
    localparam int unsigned PTR_WIDTH          = $clog2(DEPTH_DEFAULT) + 1;
    localparam int unsigned DATA_WIDTH_DEFAULT = 8;
    localparam int unsigned ADDR_WIDTH_DEFAULT = 4;
    localparam int unsigned ID_WIDTH_DEFAULT   = 2;
    localparam int unsigned USER_WIDTH_DEFAULT = 4;

    typedef logic [PTR_WIDTH-1:0] ptr_t;

    typedef struct packed {
        logic                          last;
        logic [USER_WIDTH_DEFAULT-1:0] user;
        logic [ID_WIDTH_DEFAULT-1:0]   id;
        logic [ADDR_WIDTH_DEFAULT-1:0] dest;
        logic [DATA_WIDTH_DEFAULT-1:0] data;
    } beat_t;

endpackage

// File: rtl/axis_pkt_ram.sv
// Beat storage for axis_pkt_fifo: DEPTH x WIDTH, registered write, asynchronous read.
//   clk    clock
//   we     write enable
//   waddr  write address
//   wdata  write data
//   raddr  read address
//   rdata  read data (combinational from raddr)
module axis_pkt_ram
    import axis_pkt_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEFAULT,
    parameter int unsigned WIDTH = 19
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/axis_pkt_fifo.sv
// Store-and-forward AXIS packet FIFO. A frame becomes visible downstream only once its
// tlast beat is stored; sideband (tdest, tid, tuser, tlast) is kept per beat.
//   clk, rst        single clock, synchronous active-high reset
//   s_t*            upstream AXIS slave side (s_tready = room available)
//   m_t*            downstream AXIS master side (fields driven 0 while m_tvalid=0)
//   level           stored beats, committed plus partial (wr_ptr - rd_ptr)
//   frames          complete frames stored
//   drop_count      8-bit saturating count of dropped frames (AXIS_PKT_FIFO_DROP_EN only)
// Build option AXIS_PKT_FIFO_DROP_EN: frames that would overflow are dropped. Without it,
// a frame longer than DEPTH is released cut-through so the FIFO cannot deadlock.
module axis_pkt_fifo
    import axis_pkt_pkg::*;
#(
    parameter int unsigned DEPTH           = DEPTH_DEFAULT,
    parameter int unsigned AXIS_DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter int unsigned AXIS_ADDR_WIDTH = ADDR_WIDTH_DEFAULT,
    parameter int unsigned AXIS_ID_WIDTH   = ID_WIDTH_DEFAULT,
    parameter int unsigned AXIS_USER_WIDTH = USER_WIDTH_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [AXIS_DATA_WIDTH-1:0] s_tdata,
    input  logic [AXIS_ADDR_WIDTH-1:0] s_tdest,
    input  logic [AXIS_ID_WIDTH-1:0]   s_tid,
    input  logic [AXIS_USER_WIDTH-1:0] s_tuser,
    input  logic                       s_tvalid,
    input  logic                       s_tlast,
    output logic                       s_tready,
    output logic [AXIS_DATA_WIDTH-1:0] m_tdata,
    output logic [AXIS_ADDR_WIDTH-1:0] m_tdest,
    output logic [AXIS_ID_WIDTH-1:0]   m_tid,
    output logic [AXIS_USER_WIDTH-1:0] m_tuser,
    output logic                       m_tvalid,
    output logic                       m_tlast,
    input  logic                       m_tready,
`ifdef AXIS_PKT_FIFO_DROP_EN
    output logic [7:0]                 drop_count,
`endif
    output logic [$clog2(DEPTH):0]     level,
    output logic [$clog2(DEPTH):0]     frames
);

    localparam int unsigned AW     = $clog2(DEPTH);
    localparam int unsigned PW     = AW + 1;
    localparam int unsigned BEAT_W = 1 + AXIS_USER_WIDTH + AXIS_ID_WIDTH + AXIS_ADDR_WIDTH
                                     + AXIS_DATA_WIDTH;

    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     frm_ptr_q, frm_ptr_d;
    logic [PW-1:0]     frames_q, frames_d;
    logic              full;
    logic              wr_en;
    logic              rd_en;
    logic              rd_last;
    logic [BEAT_W-1:0] wr_beat;
    logic [BEAT_W-1:0] rd_beat;
    logic [BEAT_W-1:0] m_beat;

    assign full    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign wr_beat = {s_tlast, s_tuser, s_tid, s_tdest, s_tdata};
    assign rd_last = rd_beat[BEAT_W-1];
    assign rd_en   = m_tvalid && m_tready;

    axis_pkt_ram #(
        .DEPTH (DEPTH),
        .WIDTH (BEAT_W)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr_q[AW-1:0]),
        .wdata (wr_beat),
        .raddr (rd_ptr_q[AW-1:0]),
        .rdata (rd_beat)
    );

`ifdef AXIS_PKT_FIFO_DROP_EN
    logic       drop_q;
    logic [7:0] drop_cnt_q;
    logic       accept;
    logic       drop_start;

    assign m_tvalid = (frames_q != '0);
    // While full, a beat of an uncommitted frame is still taken: it starts the drop.
    assign s_tready   = !rst && (drop_q || !full || (wr_ptr_q != frm_ptr_q));
    assign accept     = s_tvalid && s_tready;
    assign drop_start = accept && !drop_q && full;
    assign wr_en      = accept && !drop_q && !full;
    assign drop_count = drop_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_q     <= 1'b0;
            drop_cnt_q <= '0;
        end else if (drop_start) begin
            drop_q <= !s_tlast;
            if (drop_cnt_q != 8'hff) begin
                drop_cnt_q <= drop_cnt_q + 8'd1;
            end
        end else if (accept && drop_q && s_tlast) begin
            drop_q <= 1'b0;
        end
    end
`else
    logic force_q;
    logic empty;
    logic guard;

    assign empty = (wr_ptr_q == rd_ptr_q);
    // Full with no complete frame can only be a frame longer than DEPTH.
    assign guard    = full && (frames_q == '0);
    assign m_tvalid = (frames_q != '0) || guard || (force_q && !empty);
    assign s_tready = !rst && !full;
    assign wr_en    = s_tvalid && s_tready;

    always_ff @(posedge clk) begin
        if (rst) begin
            force_q <= 1'b0;
        end else if (guard) begin
            force_q <= 1'b1;
        end else if (rd_en && rd_last) begin
            force_q <= 1'b0;
        end
    end
`endif

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        frm_ptr_d = frm_ptr_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
            if (s_tlast) begin
                frm_ptr_d = wr_ptr_q + PW'(1);
            end
        end
`ifdef AXIS_PKT_FIFO_DROP_EN
        if (drop_start) begin
            wr_ptr_d = frm_ptr_q;
        end
`endif
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        frames_d = frames_q + PW'(wr_en && s_tlast) - PW'(rd_en && rd_last);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            frm_ptr_q <= '0;
            frames_q  <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            frm_ptr_q <= frm_ptr_d;
            frames_q  <= frames_d;
        end
    end

    // Memory contents are undefined until written, so fields are gated to 0 when idle.
    assign m_beat = m_tvalid ? rd_beat : '0;
    assign {m_tlast, m_tuser, m_tid, m_tdest, m_tdata} = m_beat;

    assign level  = wr_ptr_q - rd_ptr_q;
    assign frames = frames_q;

endmodule

// File: doc/axis_pkt_fifo.md
Name: axis_pkt_fifo

Overview:
- Store-and-forward packet FIFO on the 8-bit AXIS byte stream from the SPI slave front end. It feeds the downstream command/register stage.
- Buffers the beats of a frame, with sideband, and presents nothing downstream until the frame's tlast beat is stored. Downstream logic therefore never sees a partial SPI transfer.
- Slave side connects to an AXIS master modport; master side drives an AXIS slave modport.

Parameters:
- DEPTH, 16, number of beat entries; power of two, minimum 4.
- AXIS_DATA_WIDTH, 8, tdata width.
- AXIS_ADDR_WIDTH, 4, tdest width.
- AXIS_ID_WIDTH, 2, tid width.
- AXIS_USER_WIDTH, 4, tuser width.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous reset, active-high.
- s_tdata  in  8  input byte.
- s_tdest  in  4  input destination.
- s_tid  in  2  input id.
- s_tuser  in  4  input user.
- s_tvalid  in  1  input valid.
- s_tlast  in  1  input end of frame.
- s_tready  out  1  FIFO can accept.
- m_tdata  out  8  output byte.
- m_tdest  out  4  output destination.
- m_tid  out  2  output id.
- m_tuser  out  4  output user.
- m_tvalid  out  1  output valid.
- m_tlast  out  1  output end of frame.
- m_tready  in  1  downstream ready.
- level  out  clog2(DEPTH)+1  stored beats, committed plus partial.
- frames  out  clog2(DEPTH)+1  complete frames stored.

Behaviour:
- Reset: pointers, level, frames and all counters go to 0. Outputs: s_tready=0 during reset and 1 the first cycle after. m_tvalid=0, m_tlast=0. m_tdata, m_tdest, m_tid, m_tuser are don't-care but driven 0.
- Storage:
  - Each entry holds {tlast, tuser, tid, tdest, tdata}, 19 bits; sideband is kept per beat.
  - Pointers wr_ptr, rd_ptr, frm_ptr are clog2(DEPTH)+1 bits wide; the MSB is the wrap bit.
  - full when addresses are equal and wrap bits differ; empty when pointers are equal.
- Write: a beat is accepted when s_tvalid && s_tready. s_tready = !full. Writing advances wr_ptr. A beat with s_tlast=1 also sets frm_ptr <= wr_ptr+1 and increments frames.
- Read:
  - m_tvalid = (frames != 0). Output fields come combinationally from mem[rd_ptr].
  - A transfer is m_tvalid && m_tready. It advances rd_ptr; if the beat is a tlast beat, frames decrements.
- Latency: the first beat of a frame appears on m_* (m_tvalid=1) in the cycle after its tlast beat is accepted. Single-beat frames obey the same rule.
- Simultaneous tlast write and tlast read in one cycle: frames is unchanged. Simultaneous read and write when full: the write is blocked because s_tready=0 that cycle. No bypass path.
- Deadlock guard:
  - Condition: full && frames==0, i.e. a frame longer than DEPTH.
  - Behaviour with the optional feature absent: m_tvalid is forced to 1 and the open frame is released cut-through.
  - A force flag is set on the condition and cleared when the tlast of that frame is read. While the flag is set, m_tvalid = !empty.
- level = wr_ptr - rd_ptr, modular arithmetic. It is a monitor only.
- Mid-frame reset discards all contents, including a partially written frame. Downstream sees no further beats.

Optional Feature:
- Macro: AXIS_PKT_FIFO_DROP_EN.
- Defined:
  - A frame that would overflow (full while frames==0, or full on a beat of an uncommitted frame) is dropped.
  - wr_ptr rolls back to frm_ptr. s_tready is held 1 and beats are discarded until and including the next s_tlast.
  - 8-bit saturating output port drop_count increments once per dropped frame; it resets to 0.
  - The cut-through force path is removed.
- Not defined: the deadlock guard described above applies, and the drop_count port is absent.

Decomposition:
- Package axis_pkt_pkg holds:
  - the beat_t packed struct {last, user, id, dest, data};
  - localparams for DEPTH_DEFAULT and pointer width;
  - a ptr_t typedef.
- One natural sub-module, axis_pkt_ram: DEPTH x beat_t memory with registered write and asynchronous read.
- Pointer, frame-count and guard logic stay in the top.

Test Plan:
- Write 3-beat frame {0x11,0x22,0x33 last}, tdest=5, tid=1, m_tready=1:
  - m_tvalid stays 0 until the cycle after 0x33 is accepted;
  - then 0x11, 0x22, 0x33 come out on consecutive cycles with tdest=5, tid=1, tlast only on 0x33;
  - frames goes 0->1->0.
- Back-to-back frames of 1 and 2 beats with per-beat tuser 0x1, 0x2, 0x3 and m_tready held 0:
  - frames=2 and level=3;
  - releasing m_tready yields the beats in order with tuser preserved and tlast on beats 1 and 3.
- Fill to DEPTH=16 with sixteen 1-beat frames:
  - s_tready=0 at level 16;
  - one read gives s_tready=1 the next cycle;
  - a simultaneous tlast write and read leaves frames at 15.
- 20-beat frame with the macro off: at level 16 with frames=0, m_tvalid rises; all 20 bytes pass in order, tlast on the 20th.
- 20-beat frame with the macro on: no output, drop_count=1, level returns to 0. A following 2-beat frame is delivered intact.
- Assert rst after 2 beats of a 4-beat frame: level=0, frames=0, m_tvalid=0. A new 1-beat frame afterwards is delivered alone.
